// File: rtl/parity_pkg.sv
// Shared types and round-robin helper for the parity scheduler.
// Struct fields are sized for the largest supported configuration.
package parity_pkg;

  localparam int MAX_REQ    = 8;
  localparam int MAX_ID_W   = 3;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_ID_W-1:0]   id;
    logic                  exp_odd;
  } s1_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                even;
    logic                odd;
    logic                mismatch;
  } rsp_t;

  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0]  g;
    logic [MAX_ID_W-1:0] idx;
    logic                found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = MAX_ID_W'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/parity_unit.sv
// Combinational parity of one word.
// Shared by several blocks; keep it free of state.
module parity_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  output logic              odd,
  output logic              even
);

  assign odd  = ^word;
  assign even = ~odd;

endmodule

// File: rtl/parity_sched.sv
// Round-robin shared two-stage parity engine with
// expected-parity check and saturating mismatch counter.
module parity_sched
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ERR_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_exp_odd,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_even,
  output logic                       rsp_odd,
  output logic                       rsp_mismatch,
  output logic [ERR_W-1:0]           err_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic               adv1;
  logic               adv2;
  logic               take;
  logic               s1_valid;
  logic               s2_valid;
  logic [MAX_REQ-1:0] pick;
  logic [ID_W-1:0]    ptr;
  s1_t                s1_d;
  s1_t                s1_q;
  rsp_t               rsp_q;
  logic               odd;
  logic               even;

  parity_unit #(
    .DATA_W (MAX_DATA_W)
  ) u_parity (
    .word (s1_q.data),
    .odd  (odd),
    .even (even)
  );

  always_comb begin
    adv2 = !s2_valid || rsp_ready;
    adv1 = !s1_valid || adv2;
    pick = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(ptr), NUM_REQ);
    req_ready = '0;
    if (adv1 && !reset)
      req_ready = pick[NUM_REQ-1:0];
    take = |req_ready;
    s1_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        s1_d.data    = MAX_DATA_W'(req_data[i*DATA_W +: DATA_W]);
        s1_d.id      = MAX_ID_W'(i);
        s1_d.exp_odd = req_exp_odd[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      ptr       <= '0;
      s1_q      <= '0;
      rsp_q     <= '0;
      err_count <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= take;
        if (take)
          s1_q <= s1_d;
      end
      if (take)
        ptr <= ID_W'((int'(s1_d.id) + 1) % NUM_REQ);
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          rsp_q.id       <= s1_q.id;
          rsp_q.even     <= even;
          rsp_q.odd      <= odd;
          rsp_q.mismatch <= odd ^ s1_q.exp_odd;
        end
      end
      if (s2_valid && rsp_ready && rsp_q.mismatch && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  assign rsp_valid    = s2_valid;
  assign rsp_id       = rsp_q.id[ID_W-1:0];
  assign rsp_even     = rsp_q.even;
  assign rsp_odd      = rsp_q.odd;
  assign rsp_mismatch = rsp_q.mismatch;

  // high grant/id bits are structurally zero for small NUM_REQ
  logic unused_bits;
  assign unused_bits = ^{pick, rsp_q.id};

endmodule

// File: tb/tb_parity_sched.sv
// Scoreboard bench for parity_sched (NUM_REQ=4, ERR_W=2).
// Grants are modelled round-robin; responses checked in order.
module tb_parity_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int EW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_exp_odd;
  logic [NR-1:0]    req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic             rsp_even;
  logic             rsp_odd;
  logic             rsp_mismatch;
  logic [EW-1:0]    err_count;

  parity_sched #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ERR_W   (EW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_exp_odd  (req_exp_odd),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_even     (rsp_even),
    .rsp_odd      (rsp_odd),
    .rsp_mismatch (rsp_mismatch),
    .err_count    (err_count)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  logic [5:0] sb[$];
  int         glog[$];
  int         mptr = 0;
  int         exp_err = 0;
  logic       hold = 1'b0;
  logic [5:0] prev_out;
  logic [5:0] e;
  logic [5:0] cur;
  logic [NR-1:0] exp_g;
  int         g;
  logic [DW-1:0] w;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: grant model, scoreboard, error-count model, hold check
  always @(negedge clock) begin
    if (reset) begin
      check("rst_ready", req_ready, 0);
      sb.delete();
      mptr    = 0;
      exp_err = 0;
      hold    = 1'b0;
    end else begin
      cur = {1'b0, rsp_id, rsp_even, rsp_odd, rsp_mismatch};
      check("err_count", err_count, exp_err);
      if (hold)
        check("hold", {rsp_valid, cur}, {1'b1, prev_out});
      if (req_ready != 0) begin
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(mptr + k) % NR])
            g = (mptr + k) % NR;
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("grant", req_ready, exp_g);
        if (g >= 0) begin
          w = req_data[g*DW +: DW];
          e = {3'(g), ~(^w), ^w, (^w) ^ req_exp_odd[g]};
          sb.push_back(e);
          glog.push_back(g);
          mptr = (g + 1) % NR;
        end
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp", cur, e);
          if (e[0] && exp_err < 3) exp_err++;
        end
      end
      hold     = rsp_valid && !rsp_ready;
      prev_out = cur;
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic send1(int i, logic [DW-1:0] d, logic x);
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    req_data[i*DW +: DW] = d;
    req_exp_odd[i]       = x;
    req_valid[i]         = 1'b1;
    while (n < 50 && !got) begin
      @(negedge clock);
      if (req_ready[i]) got = 1'b1;
      n++;
    end
    check("grant_to", got, 1);
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(rsp_valid && rsp_ready) && n < 50);
    check("rsp_to", rsp_valid && rsp_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    req_valid   = '1;
    req_data    = '0;
    req_exp_odd = '0;
    rsp_ready   = 1'b1;
    @(posedge clock); #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_out", {rsp_id, rsp_even, rsp_odd, rsp_mismatch}, 0);
    check("rst_err", err_count, 0);
    check("rst_rdy", req_ready, 0);
    req_valid = '0;
    reset     = 1'b0;

    // single word, latency and parity
    send1(0, 32'h0000_0003, 1'b0);
    wait_rsp(n);
    check("t1_lat", n, 2);
    check("t1_rsp", {rsp_id, rsp_even, rsp_odd, rsp_mismatch}, 5'b00100);
    @(posedge clock); #1;
    check("t1_err", err_count, 0);

    // mismatch
    send1(2, 32'h0000_0007, 1'b0);
    wait_rsp(n);
    check("t2_rsp", {rsp_id, rsp_odd, rsp_mismatch}, 4'b1011);
    @(posedge clock); #1;
    check("t2_err", err_count, 1);

    // fairness
    do_reset();
    glog.delete();
    for (int i = 0; i < NR; i++)
      req_data[i*DW +: DW] = 32'h1000_0000 * (i + 1) + 32'(i);
    req_exp_odd = 4'b0110;
    req_valid   = '1;
    repeat (8) @(posedge clock);
    #1;
    req_valid = '0;
    check("t3_cnt", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      check("t3_order", glog[k], k % NR);
    drain();

    // backpressure
    do_reset();
    glog.delete();
    rsp_ready = 1'b0;
    req_data[1*DW +: DW] = 32'h0000_00F1;
    req_data[3*DW +: DW] = 32'h8000_0001;
    req_exp_odd = 4'b0000;
    req_valid   = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k >= 2) check("t4_stall", req_ready, 0);
    end
    @(posedge clock); #1;
    req_valid = '0;
    check("t4_cnt", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t4_g0", glog[0], 1);
      check("t4_g1", glog[1], 3);
    end
    rsp_ready = 1'b1;
    drain();
    req_valid = '1;
    @(negedge clock);
    check("t4_ptr", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    // saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send1(0, 32'h0000_0001, 1'b0);
      wait_rsp(n);
      @(posedge clock); #1;
      check("t5_sat", err_count, (k < 3) ? k + 1 : 3);
    end

    // reset with both stages full
    do_reset();
    rsp_ready = 1'b0;
    fork
      send1(0, 32'h0000_0001, 1'b1);
      send1(1, 32'h0000_0001, 1'b1);
    join
    reset = 1'b1;
    req_data[0*DW +: DW] = 32'h0000_0003;
    req_exp_odd = '0;
    req_valid   = '1;
    @(posedge clock); #1;
    check("t6_valid", rsp_valid, 0);
    check("t6_out", {rsp_id, rsp_even, rsp_odd, rsp_mismatch}, 0);
    check("t6_rdy", req_ready, 0);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("t6_ptr", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/parity_sched.md
Name: parity_sched

Overview:
- Shares one pipelined parity engine among NUM_REQ requesters using round-robin arbitration.
- Each accepted word returns even/odd parity tagged with the requester ID.
- Checks the result against a requester-supplied expected parity and counts mismatches.
- Sits between the bus-side word sources and the error/status logic; replaces per-source ad-hoc parity flops.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data word width.
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridable).
- ERR_W, 8, mismatch counter width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word-valid.
- req_data  in  NUM_REQ*DATA_W  flat packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_exp_odd  in  NUM_REQ  per-requester expected odd parity (1 = odd number of ones expected).
- req_ready  out  NUM_REQ  one-hot grant; word i is accepted when req_valid[i] && req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  ID_W  requester of the result.
- rsp_even  out  1  1 when the word has an even number of ones.
- rsp_odd  out  1  always ~rsp_even while rsp_valid.
- rsp_mismatch  out  1  rsp_odd != expected odd.
- err_count  out  ERR_W  saturating mismatch count.

Behaviour:
- Reset values:
  - All pipeline valids = 0, so req_ready = 0, rsp_valid = 0.
  - rsp_id = 0, rsp_even = 0, rsp_odd = 0, rsp_mismatch = 0, err_count = 0.
  - RR pointer = 0.
- Reset mid-operation drops all in-flight words with no response; the pointer returns to 0.
- Pipeline: stage S1 (capture word/id/expected), then stage S2 (parity registered = output regs).
  - Latency: accept in cycle N -> rsp_valid in cycle N+2, if unstalled.
  - Throughput: 1 word/cycle.
- Pipeline control:
  - adv2 = !s2_valid || rsp_ready.
  - adv1 = !s1_valid || adv2.
  - S1 loads only when adv1. S2 loads S1 when adv2.
  - Output registers hold stable while rsp_valid && !rsp_ready.
- req_ready:
  - Combinational from arbitration and adv1.
  - At most one bit is set, and only when adv1 = 1 and that requester's req_valid = 1.
  - Never asserted during reset.
- Round-robin arbitration:
  - Search starts at ptr, ascending with wrap to 0, and picks the first req_valid.
  - On an accepted grant to i: ptr <= (i+1) mod NUM_REQ.
  - No grant (no valid, or stall): ptr unchanged.
  - Wrap: grant to NUM_REQ-1 sets ptr = 0.
- Parity:
  - odd = ^word, even = ~odd.
  - mismatch = odd ^ exp_odd, computed in the S1 -> S2 transfer.
- err_count:
  - Increments by 1 when a result handshake (rsp_valid && rsp_ready) has rsp_mismatch = 1.
  - Saturates at 2^ERR_W-1 and never wraps.
- Simultaneous events:
  - A result handshake and a new S1 -> S2 load in the same cycle is allowed; no bubble.
  - A requester deasserting req_valid without a grant is legal; its word is dropped and never partially processed.
- Backpressure full case:
  - S1 and S2 both valid and rsp_ready = 0 -> req_ready = 0.
  - No words are lost or duplicated.

Decomposition:
- Package parity_pkg:
  - Typedef s1_t {data, id, exp_odd}.
  - Typedef rsp_t {id, even, odd, mismatch}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module parity_unit:
  - Purely combinational: DATA_W word in -> odd, even out.
  - Reused by other blocks in the codebase.
- Top level parity_sched holds the arbiter, both pipeline stages and the counter.

Test Plan:
- Single word: requester 0 sends 0x0000_0003, exp_odd = 0, rsp_ready = 1.
  -> Two cycles after acceptance: rsp_valid, rsp_id = 0, rsp_even = 1, rsp_odd = 0, rsp_mismatch = 0, err_count = 0.
- Mismatch: requester 2 sends 0x0000_0007, exp_odd = 0.
  -> rsp_odd = 1, rsp_mismatch = 1, err_count = 1 after the handshake.
- Fairness: all 4 requesters hold valid continuously for 8 cycles.
  -> Grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order two cycles later.
- Backpressure: rsp_ready = 0 for 5 cycles with requesters 1 and 3 valid.
  -> Exactly two words accepted, then req_ready = 0 and outputs stable.
  -> On release, responses ids 1,3 arrive in order with no loss or duplicate; ptr = 0 afterwards.
- Saturation: ERR_W = 2, send 5 mismatching words.
  -> err_count sequence 1,2,3,3,3.
- Reset mid-flight: assert reset with S1 and S2 valid.
  -> Next cycle all outputs at reset values, ptr = 0, and no response for the dropped words.
